// File: rtl/vx_dcr_launcher_pkg.sv
// Shared types for the DCR launch sequencer.
// Table entry layout and FSM state encoding.
package vx_dcr_launcher_pkg;

    localparam int VX_DCR_ADDR_WIDTH = 12;
    localparam int VX_DCR_DATA_WIDTH = 32;

    typedef struct packed {
        logic [VX_DCR_ADDR_WIDTH-1:0] addr;
        logic [VX_DCR_DATA_WIDTH-1:0] data;
    } vx_dcr_entry_t;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_BUSY = 3'd2,
        RUN       = 3'd3,
        DONE      = 3'd4
    } vx_launch_state_e;

endpackage

// File: rtl/vx_dcr_launch_table.sv
// DCR (addr,data) table for the launch sequencer.
// One write port, one combinational read port, no data reset.
module vx_dcr_launch_table
    import vx_dcr_launcher_pkg::*;
#(
    parameter int NUM_ENTRIES = 8,
    localparam int CW = $clog2(NUM_ENTRIES + 1)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [CW-1:0] widx,
    input  vx_dcr_entry_t wentry,
    input  logic [CW-1:0] ridx,
    output vx_dcr_entry_t rentry
);

    localparam int AW = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
    localparam logic [CW-1:0] DEPTH = CW'(NUM_ENTRIES);

    vx_dcr_entry_t mem [NUM_ENTRIES];

    // Store an entry; indices past the end are never written.
    always_ff @(posedge clk) begin
        if (we && (widx < DEPTH)) begin
            mem[widx[AW-1:0]] <= wentry;
        end
    end

    assign rentry = (ridx < DEPTH) ? mem[ridx[AW-1:0]] : '0;

endmodule

// File: rtl/vx_dcr_launcher.sv
// Launch sequencer: replays a DCR table into VX_top,
// then follows busy through run and reports done/error.
module vx_dcr_launcher
    import vx_dcr_launcher_pkg::*;
#(
    parameter int NUM_ENTRIES  = 8,
    parameter int BUSY_TIMEOUT = 1024,
    parameter int ADDR_W       = VX_DCR_ADDR_WIDTH,
    parameter int DATA_W       = VX_DCR_DATA_WIDTH,
    localparam int CW          = $clog2(NUM_ENTRIES + 1),
    localparam int TW          = $clog2(BUSY_TIMEOUT)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [DATA_W-1:0] cfg_data,
    input  logic              cfg_clear,
    output logic [CW-1:0]     cfg_count,
    input  logic              start,
    output logic              write_valid,
    output logic [ADDR_W-1:0] write_addr,
    output logic [DATA_W-1:0] write_data,
    input  logic              gpu_busy,
    output logic              done,
    output logic              error,
    output logic [2:0]        state_o
);

    localparam logic [CW-1:0] FULL  = CW'(NUM_ENTRIES);
    localparam logic [TW-1:0] TLAST = TW'(BUSY_TIMEOUT - 1);

    vx_launch_state_e  state, state_n;
    logic [CW-1:0]     count, count_n;
    logic [CW-1:0]     index, index_n;
    logic [TW-1:0]     timer, timer_n;
    logic              error_q, error_n;
    logic              wv_q, wv_n;
    logic [ADDR_W-1:0] wa_q, wa_n;
    logic [DATA_W-1:0] wd_q, wd_n;
    logic              tbl_we;
    logic [CW-1:0]     rd_idx;
    vx_dcr_entry_t     wr_entry;
    vx_dcr_entry_t     rd_entry;

    assign wr_entry = '{addr: cfg_addr, data: cfg_data};
    assign rd_idx   = (state == IDLE) ? '0 : index;

    vx_dcr_launch_table #(
        .NUM_ENTRIES(NUM_ENTRIES)
    ) u_table (
        .clk   (clk),
        .we    (tbl_we),
        .widx  (count),
        .wentry(wr_entry),
        .ridx  (rd_idx),
        .rentry(rd_entry)
    );

    assign cfg_ready   = (state == IDLE) && (count < FULL) && !start;
    assign cfg_count   = count;
    assign write_valid = wv_q;
    assign write_addr  = wa_q;
    assign write_data  = wd_q;
    assign done        = (state == DONE);
    assign error       = error_q;
    assign state_o     = state;

    // Next-state, counters, table push and the registered write port.
    always_comb begin
        state_n = state;
        count_n = count;
        index_n = index;
        timer_n = timer;
        error_n = error_q;
        wv_n    = 1'b0;
        wa_n    = wa_q;
        wd_n    = wd_q;
        tbl_we  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (count != '0) begin
                        state_n = ISSUE;
                        index_n = CW'(1);
                        error_n = 1'b0;
                        wv_n    = 1'b1;
                        wa_n    = rd_entry.addr;
                        wd_n    = rd_entry.data;
                    end else begin
                        state_n = DONE;
                        error_n = 1'b1;
                    end
                end else if (cfg_clear) begin
                    count_n = '0;
                end else if (cfg_valid && cfg_ready) begin
                    tbl_we  = 1'b1;
                    count_n = count + 1'b1;
                end
            end
            ISSUE: begin
                if (index < count) begin
                    wv_n    = 1'b1;
                    wa_n    = rd_entry.addr;
                    wd_n    = rd_entry.data;
                    index_n = index + 1'b1;
                end else begin
                    state_n = WAIT_BUSY;
                    timer_n = '0;
                end
            end
            WAIT_BUSY: begin
                if (gpu_busy) begin
                    state_n = RUN;
                end else if (timer == TLAST) begin
                    state_n = DONE;
                    error_n = 1'b1;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            RUN: begin
                if (!gpu_busy) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            count   <= '0;
            index   <= '0;
            timer   <= '0;
            error_q <= 1'b0;
            wv_q    <= 1'b0;
            wa_q    <= '0;
            wd_q    <= '0;
        end else begin
            state   <= state_n;
            count   <= count_n;
            index   <= index_n;
            timer   <= timer_n;
            error_q <= error_n;
            wv_q    <= wv_n;
            wa_q    <= wa_n;
            wd_q    <= wd_n;
        end
    end

endmodule

// File: tb/tb_vx_dcr_launcher.sv
// Bench for vx_dcr_launcher: timeline model plus
// directed launches with hand-computed expectations.
module tb_vx_dcr_launcher;

    localparam int NE = 8;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cfg_valid = 1'b0;
    logic        cfg_clear = 1'b0;
    logic        start = 1'b0;
    logic        gpu_busy = 1'b0;
    logic [11:0] cfg_addr = '0;
    logic [31:0] cfg_data = '0;
    logic        cfg_ready;
    logic [3:0]  cfg_count;
    logic        write_valid;
    logic [11:0] write_addr;
    logic [31:0] write_data;
    logic        done;
    logic        error;
    logic [2:0]  state_o;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    vx_dcr_launcher #(
        .NUM_ENTRIES (NE),
        .BUSY_TIMEOUT(TO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .cfg_clear  (cfg_clear),
        .cfg_count  (cfg_count),
        .start      (start),
        .write_valid(write_valid),
        .write_addr (write_addr),
        .write_data (write_data),
        .gpu_busy   (gpu_busy),
        .done       (done),
        .error      (error),
        .state_o    (state_o)
    );

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, got, exp);
        end
    endtask

    // Model: mode 0 idle,1 issue,2 wait,3 run,4 done.
    // Writes come from the launch timestamp: slot k at T+1+k.
    logic [11:0] m_ta [NE];
    logic [31:0] m_td [NE];
    int          m_cnt = 0, m_md = 0, m_t0 = 0, m_n = 0, m_wbeg = 0;
    bit          m_err = 0, m_wv = 0, m_ok = 0;
    logic [11:0] m_wa = '0;
    logic [31:0] m_wd = '0;

    always @(posedge clk) begin
        int nc, k;
        nc = cyc + 1;
        if (reset) begin
            m_md = 0; m_cnt = 0; m_err = 0; m_wv = 0;
            m_wa = '0; m_wd = '0; m_ok = 1;
        end else begin
            m_wv = 0;
            case (m_md)
                0: begin
                    if (start) begin
                        if (m_cnt > 0) begin
                            m_t0 = cyc; m_n = m_cnt; m_err = 0; m_md = 1;
                        end else begin
                            m_err = 1; m_md = 4;
                        end
                    end else if (cfg_clear) begin
                        m_cnt = 0;
                    end else if (cfg_valid && m_cnt < NE) begin
                        m_ta[m_cnt] = cfg_addr;
                        m_td[m_cnt] = cfg_data;
                        m_cnt++;
                    end
                end
                2: begin
                    if (gpu_busy) m_md = 3;
                    else if (cyc - m_wbeg == TO - 1) begin
                        m_md = 4; m_err = 1;
                    end
                end
                3: if (!gpu_busy) m_md = 4;
                4: m_md = 0;
                default: ;
            endcase
            if (m_md == 1) begin
                k = nc - m_t0 - 1;
                if (k < m_n) begin
                    m_wv = 1; m_wa = m_ta[k]; m_wd = m_td[k];
                end else begin
                    m_md = 2; m_wbeg = nc;
                end
            end
        end
        cyc = nc;
    end

    always @(negedge clk) begin
        if (m_ok) begin
            chk("m_state", state_o, m_md);
            chk("m_cfg_count", cfg_count, m_cnt);
            chk("m_cfg_ready", cfg_ready, (m_md == 0 && m_cnt < NE && !start));
            chk("m_write_valid", write_valid, m_wv);
            chk("m_write_addr", write_addr, m_wa);
            chk("m_write_data", write_data, m_wd);
            chk("m_done", done, (m_md == 4));
            chk("m_error", error, m_err);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic push(input logic [11:0] a, input logic [31:0] d);
        cfg_valid = 1'b1; cfg_addr = a; cfg_data = d;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic clear_tbl();
        cfg_clear = 1'b1;
        tick();
        cfg_clear = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int lim);
        bit seen;
        seen = 0;
        for (int i = 0; i < lim && !seen; i++) begin
            mid();
            if (done) seen = 1;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s got=no_done exp=done within %0d", nm, lim);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        mid();
        chk("rst_state", state_o, 0);
        chk("rst_ready", cfg_ready, 1);
        chk("rst_count", cfg_count, 0);
        chk("rst_wv", write_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        tick();

        // 1: three-entry launch, busy 1 at T+6, 0 at T+20
        push(12'h001, 32'h8000_0000);
        push(12'h002, 32'h0);
        push(12'h003, 32'h1234);
        start = 1'b1; tick(); start = 1'b0;
        mid();
        chk("t1_wv1", write_valid, 1);
        chk("t1_a1", write_addr, 12'h001);
        chk("t1_d1", write_data, 32'h8000_0000);
        tick(); mid();
        chk("t1_a2", write_addr, 12'h002);
        chk("t1_d2", write_data, 32'h0);
        tick(); mid();
        chk("t1_a3", write_addr, 12'h003);
        chk("t1_d3", write_data, 32'h1234);
        tick(); mid();
        chk("t1_wv4", write_valid, 0);
        chk("t1_wait", state_o, 2);
        tick(); tick();
        gpu_busy = 1'b1;
        repeat (14) tick();
        gpu_busy = 1'b0;
        tick(); mid();
        chk("t1_done", done, 1);
        chk("t1_err", error, 0);
        tick();

        // 2: fill table, stalled 9th entry, clear
        clear_tbl();
        for (int i = 0; i < NE; i++) push(12'(16 + i), 32'(i * 32'h1111));
        cfg_valid = 1'b1; cfg_addr = 12'h099; cfg_data = 32'h9;
        mid();
        chk("t2_ready", cfg_ready, 0);
        chk("t2_cnt8", cfg_count, 8);
        tick(); tick(); tick();
        cfg_valid = 1'b0;
        mid();
        chk("t2_cnt_held", cfg_count, 8);
        tick();
        clear_tbl();
        mid();
        chk("t2_cnt_clr", cfg_count, 0);
        tick();

        // 3: busy never rises, timeout after 16 waiting cycles
        push(12'h010, 32'hdead_beef);
        start = 1'b1; tick(); start = 1'b0;
        repeat (17) tick();
        mid();
        chk("t3_done", done, 1);
        chk("t3_err", error, 1);
        tick(); mid();
        chk("t3_err_sticky", error, 1);
        tick(); tick(); tick(); mid();
        chk("t3_err_idle", error, 1);
        tick();
        start = 1'b1; tick(); start = 1'b0;
        gpu_busy = 1'b1;
        mid();
        chk("t3_err_clr", error, 0);
        chk("t3_a", write_addr, 12'h010);
        tick(); tick(); tick();
        gpu_busy = 1'b0;
        wait_done("t3_relaunch", 10);
        tick();

        // 4: empty launch, then start+cfg_valid together
        clear_tbl();
        start = 1'b1; tick(); start = 1'b0;
        mid();
        chk("t4_done", done, 1);
        chk("t4_err", error, 1);
        chk("t4_wv", write_valid, 0);
        tick();
        push(12'h020, 32'h55);
        start = 1'b1; cfg_valid = 1'b1;
        cfg_addr = 12'h021; cfg_data = 32'h66;
        mid();
        chk("t4_ready_start", cfg_ready, 0);
        tick();
        start = 1'b0; cfg_valid = 1'b0;
        mid();
        chk("t4_cnt", cfg_count, 1);
        chk("t4_a", write_addr, 12'h020);
        chk("t4_d", write_data, 32'h55);
        tick();
        gpu_busy = 1'b1;
        tick(); tick();
        gpu_busy = 1'b0;
        wait_done("t4_run", 10);
        tick();

        // 5: reset after 2 of 5 writes
        clear_tbl();
        for (int i = 0; i < 5; i++) push(12'(48 + i), 32'(1280 + i));
        start = 1'b1; tick(); start = 1'b0;
        tick();
        reset = 1'b1;
        mid();
        chk("t5_a2", write_addr, 12'h031);
        tick();
        reset = 1'b0;
        mid();
        chk("t5_wv", write_valid, 0);
        chk("t5_cnt", cfg_count, 0);
        chk("t5_state", state_o, 0);
        chk("t5_done", done, 0);
        repeat (4) tick();

        // 6: busy already high, ignored start in RUN, relaunch
        push(12'h040, 32'h4000);
        push(12'h041, 32'h4001);
        start = 1'b1; tick(); start = 1'b0;
        gpu_busy = 1'b1;
        tick(); tick(); tick();
        mid();
        chk("t6_run", state_o, 3);
        tick();
        start = 1'b1; tick(); start = 1'b0;
        mid();
        chk("t6_run_hold", state_o, 3);
        chk("t6_no_wv", write_valid, 0);
        tick(); tick();
        gpu_busy = 1'b0;
        tick(); mid();
        chk("t6_done", done, 1);
        tick();
        start = 1'b1; tick(); start = 1'b0;
        mid();
        chk("t6_re_a0", write_addr, 12'h040);
        chk("t6_re_d0", write_data, 32'h4000);
        tick(); mid();
        chk("t6_re_a1", write_addr, 12'h041);
        chk("t6_re_d1", write_data, 32'h4001);
        tick();
        gpu_busy = 1'b1;
        tick(); tick();
        gpu_busy = 1'b0;
        wait_done("t6_relaunch", 10);
        tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
